// File: rtl/move_sequencer_pkg.sv
// rtl/move_sequencer_pkg.sv - shared chess-clock encodings and field positions
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN_WHITE = 2'd1,
    ST_RUN_BLACK = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam int TURN_BIT = 13;
  localparam int FROM_MSB = 12;
  localparam int FROM_LSB = 7;
  localparam int TO_MSB   = 6;
  localparam int TO_LSB   = 1;
  localparam int CAP_BIT  = 0;

  localparam int MIN_MSB = 8;
  localparam int MIN_LSB = 6;
  localparam int SEC_MSB = 5;
  localparam int SEC_LSB = 0;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  // A side has flagged once both minutes and seconds read zero.
  function automatic logic flag_down(input logic [MIN_MSB:0] cd);
    return (cd[MIN_MSB:MIN_LSB] == '0) && (cd[SEC_MSB:SEC_LSB] == '0);
  endfunction

endpackage

// File: rtl/move_sequencer_tick_divider.sv
// rtl/move_sequencer_tick_divider.sv - one-second strobe divider, held at zero when disabled
module tick_divider #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - chess game-flow controller: move handshake, turn toggle, flag fall
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_valid,
  input  logic [5:0]  move_from,
  input  logic [5:0]  move_to,
  input  logic        move_capture,
  output logic        move_ready,
  output logic        illegal_move,
  input  logic [9:0]  countdownWhite,
  input  logic [9:0]  countdownBlack,
  output logic [13:0] moveData,
  output logic        sec_tick,
  output logic [7:0]  move_count,
  output logic        timeout,
  output logic        winner
);

  state_e      state_q, state_d;
  logic [13:0] move_data_q, move_data_d;
  logic [7:0]  move_count_q, move_count_d;
  logic        winner_q, winner_d;
  logic        illegal_q, illegal_d;
  logic        running, side, flag_fall, offered, accept;
  logic        unused_bits;

  assign unused_bits = countdownWhite[9] ^ countdownBlack[9];

  always_comb begin
    state_d      = state_q;
    move_data_d  = move_data_q;
    move_count_d = move_count_q;
    winner_d     = winner_q;
    illegal_d    = 1'b0;

    running   = (state_q == ST_RUN_WHITE) || (state_q == ST_RUN_BLACK);
    side      = (state_q == ST_RUN_BLACK) ? BLACK : WHITE;
    // Only the running side's countdown is examined; flag fall pre-empts any move.
    flag_fall = running && flag_down((side == BLACK) ? countdownBlack[8:0]
                                                     : countdownWhite[8:0]);
    offered   = running && move_valid && !flag_fall;
    accept    = offered && (move_from != move_to);

    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_RUN_WHITE;
      ST_RUN_WHITE: if (flag_fall) state_d = ST_GAME_OVER;
                    else if (accept) state_d = ST_RUN_BLACK;
      ST_RUN_BLACK: if (flag_fall) state_d = ST_GAME_OVER;
                    else if (accept) state_d = ST_RUN_WHITE;
      default:      state_d = ST_GAME_OVER;
    endcase

    if (flag_fall) begin
      winner_d = ~side;
    end

    if (accept) begin
      move_data_d[TURN_BIT]          = ~move_data_q[TURN_BIT];
      move_data_d[FROM_MSB:FROM_LSB] = move_from;
      move_data_d[TO_MSB:TO_LSB]     = move_to;
      move_data_d[CAP_BIT]           = move_capture;
      if (move_count_q != 8'hFF) begin
        move_count_d = move_count_q + 8'd1;
      end
    end

    if (offered && (move_from == move_to)) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      move_data_q  <= '0;
      move_count_q <= '0;
      winner_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_data_q  <= move_data_d;
      move_count_q <= move_count_d;
      winner_q     <= winner_d;
      illegal_q    <= illegal_d;
    end
  end

  tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_divider (
    .clk (clk),
    .rst (rst),
    .en  (running),
    .tick(sec_tick)
  );

  assign move_ready   = running;
  assign illegal_move = illegal_q;
  assign moveData     = move_data_q;
  assign move_count   = move_count_q;
  assign timeout      = (state_q == ST_GAME_OVER);
  assign winner       = winner_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - self-checking bench for move_sequencer with a game-level reference model
module tb_move_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst, start, move_valid, move_capture;
  logic [5:0]  move_from, move_to;
  logic [9:0]  countdownWhite, countdownBlack;
  logic        move_ready, illegal_move, sec_tick, timeout, winner;
  logic [13:0] moveData;
  logic [7:0]  move_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  move_sequencer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .start(start),
    .move_valid(move_valid), .move_from(move_from), .move_to(move_to),
    .move_capture(move_capture), .move_ready(move_ready), .illegal_move(illegal_move),
    .countdownWhite(countdownWhite), .countdownBlack(countdownBlack),
    .moveData(moveData), .sec_tick(sec_tick), .move_count(move_count),
    .timeout(timeout), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase 0 idle, 1 running, 2 over; m_cyc counts cycles since the game began.
  int         m_phase, m_count, m_cyc, m_rem;
  logic       m_side, m_winner, m_illegal, m_cap;
  logic [5:0] m_from, m_to;
  logic [9:0] m_cd;

  always @(posedge clk) begin
    m_illegal = 1'b0;
    if (rst) begin
      m_phase = 0; m_side = 0; m_winner = 0; m_count = 0; m_cyc = 0;
      m_from = 0; m_to = 0; m_cap = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_side = 0; m_cyc = 0;
      end
    end else if (m_phase == 1) begin
      m_cd  = m_side ? countdownBlack : countdownWhite;
      m_rem = int'(m_cd[8:6]) * 60 + int'(m_cd[5:0]);
      if (m_rem == 0) begin
        m_phase  = 2;
        m_winner = !m_side;
      end else begin
        m_cyc++;
        if (move_valid) begin
          if (move_from == move_to) m_illegal = 1'b1;
          else begin
            m_from = move_from; m_to = move_to; m_cap = move_capture;
            m_side = !m_side;
            m_count = (m_count < 255) ? m_count + 1 : 255;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ready",   32'(move_ready),   32'(m_phase == 1));
      check("model_timeout", 32'(timeout),      32'(m_phase == 2));
      check("model_winner",  32'(winner),       32'(m_winner));
      check("model_illegal", 32'(illegal_move), 32'(m_illegal));
      check("model_count",   32'(move_count),   32'(m_count));
      check("model_movedata", 32'(moveData), 32'({m_side, m_from, m_to, m_cap}));
      check("model_tick", 32'(sec_tick), 32'((m_phase == 1) && ((m_cyc % T) == T - 1)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] f, input logic [5:0] t, input logic c);
    move_valid = 1'b1; move_from = f; move_to = t; move_capture = c;
  endtask

  task automatic restart();
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
  endtask

  int ticks, first_tick;

  initial begin
    rst = 1'b1; start = 1'b0; move_valid = 1'b0;
    move_from = '0; move_to = '0; move_capture = 1'b0;
    countdownWhite = 10'd64; countdownBlack = 10'd64;
    step(); cmp_en = 1'b1; step();

    check("reset_movedata", 32'(moveData), 32'h0);
    check("reset_ready", 32'(move_ready), 32'h0);
    check("reset_count", 32'(move_count), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    rst = 1'b0; step(); step();
    check("idle_ready", 32'(move_ready), 32'h0);

    start = 1'b1; step(); start = 1'b0;
    check("start_ready", 32'(move_ready), 32'h1);
    ticks = 0; first_tick = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      if (sec_tick) begin
        ticks++;
        if (first_tick < 0) first_tick = k;
      end
    end
    check("tick_count", 32'(ticks), 32'd2);
    check("tick_first", 32'(first_tick), 32'd3);

    offer(6'd12, 6'd28, 1'b0); step();
    check("move1_data", 32'(moveData), 32'h2638);
    check("move1_count", 32'(move_count), 32'd1);
    check("move1_ready", 32'(move_ready), 32'h1);
    offer(6'd52, 6'd36, 1'b1); step();
    check("move2_data", 32'(moveData), 32'h1A49);
    check("move2_count", 32'(move_count), 32'd2);

    offer(6'd5, 6'd5, 1'b0); step();
    check("null_pulse", 32'(illegal_move), 32'h1);
    check("null_data", 32'(moveData), 32'h1A49);
    check("null_count", 32'(move_count), 32'd2);
    move_valid = 1'b0; step();
    check("null_pulse_end", 32'(illegal_move), 32'h0);

    countdownWhite = 10'd0; countdownBlack = 10'd0; step();
    check("wflag_timeout", 32'(timeout), 32'h1);
    check("wflag_winner", 32'(winner), 32'h1);
    check("wflag_ready", 32'(move_ready), 32'h0);
    start = 1'b1;
    repeat (6) step();
    start = 1'b0;
    check("over_hold", 32'({timeout, winner, sec_tick}), 32'b110);
    countdownWhite = 10'd64; countdownBlack = 10'd64;

    restart();
    offer(6'd10, 6'd20, 1'b0); step(); move_valid = 1'b0;
    countdownBlack = 10'd0; offer(6'd1, 6'd2, 1'b0); step();
    move_valid = 1'b0;
    check("bflag_timeout", 32'(timeout), 32'h1);
    check("bflag_winner", 32'(winner), 32'h0);
    check("bflag_count", 32'(move_count), 32'd1);
    check("bflag_data", 32'(moveData), 32'h2528);
    check("bflag_illegal", 32'(illegal_move), 32'h0);
    countdownBlack = 10'd64;

    restart();
    for (int i = 0; i < 256; i++) begin
      offer(6'(i % 64), 6'((i + 1) % 64), 1'(i & 1));
      step();
    end
    check("sat_count", 32'(move_count), 32'd255);
    check("sat_turn", 32'(moveData[13]), 32'h0);
    offer(6'd3, 6'd4, 1'b0); step();
    check("sat_hold", 32'(move_count), 32'd255);
    check("sat_data", 32'(moveData), 32'h2188);
    rst = 1'b1; step();
    check("mid_rst", 32'({moveData, move_count, move_ready, timeout, winner, sec_tick, illegal_move}),
          32'h0);
    rst = 1'b0; move_valid = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Game-flow controller that drives the chess clock's `moveData` word and consumes its two countdown buses. It accepts moves from the board/input logic through a valid/ready handshake, toggles the side to move, and generates the one-second strobe that paces the clock. It also watches the side-to-move countdown for flag fall and ends the game with a winner.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100_000_000: `clk` cycles per one-second strobe; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; begins a game from IDLE.
- `move_valid`  in  1  move offered.
- `move_from`  in  6  source square, 0–63.
- `move_to`  in  6  destination square, 0–63.
- `move_capture`  in  1  move captures a piece.
- `move_ready`  out  1  sequencer can accept a move.
- `illegal_move`  out  1  one-cycle pulse: offered move rejected.
- `countdownWhite`  in  10  white remaining time; [8:6] minutes, [5:0] seconds, [9] ignored.
- `countdownBlack`  in  10  black remaining time; same format.
- `moveData`  out  14  [13] side whose clock runs (1 = black), [12:7] last from, [6:1] last to, [0] last capture.
- `sec_tick`  out  1  one-cycle pulse per second while running.
- `move_count`  out  8  accepted half-moves, saturating at 255.
- `timeout`  out  1  high in GAME_OVER.
- `winner`  out  1  valid when `timeout`: 0 = white, 1 = black.

## Operation
- States: IDLE, RUN_WHITE, RUN_BLACK, GAME_OVER.
- IDLE → RUN_WHITE when `start` = 1.
- RUN_WHITE ↔ RUN_BLACK on each accepted move.
- RUN_x → GAME_OVER on flag fall of side x.
- GAME_OVER holds until `rst`; `start` is ignored there.
- `move_ready` = 1 only in RUN_WHITE/RUN_BLACK, combinational from state.
- Accept = `move_valid` & `move_ready` & (`move_from` ≠ `move_to`).
- On accept:
  - `moveData[12:0]` ← {from, to, capture}.
  - `moveData[13]` ← toggled.
  - `move_count` increments, saturating at 255.
- Offered move with `move_from` = `move_to` while ready: no state change, `illegal_move` pulses for one cycle.
- Moves offered outside RUN states are ignored silently, with no pulse.
- Flag fall:
  - In RUN_WHITE: `countdownWhite[8:0]` = 0. In RUN_BLACK: `countdownBlack[8:0]` = 0.
  - The non-running side's countdown is never examined.
  - `winner` ← opposite side of the one that flagged.
- Tick divider:
  - Counter 0..TICKS_PER_SEC−1, runs only in RUN states; held at 0 in IDLE and GAME_OVER.
  - `sec_tick` = 1 in the cycle the counter equals TICKS_PER_SEC−1, after which it wraps to 0.
  - The counter is not cleared on a move.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - State IDLE, `moveData` = 14'h0000, `move_count` = 0.
  - `timeout` = 0, `winner` = 0, `sec_tick` = 0, `illegal_move` = 0, divider = 0.
- `rst` mid-game takes priority over every other input in that cycle.
- Outputs are registered, except `move_ready`.
- Accept in cycle N:
  - `moveData` and `move_count` update at N+1.
  - State toggles at N+1, so `move_ready` stays high across the toggle and back-to-back moves on consecutive cycles are legal.
- Flag fall is sampled in cycle N; at N+1 state = GAME_OVER, `timeout` = 1, `move_ready` = 0.
- Flag fall and an accept in the same cycle: flag fall wins.
  - The move is dropped: `moveData` and `move_count` are unchanged, and no `illegal_move` pulse.
- `sec_tick` and an accept in the same cycle: both take effect; the tick is charged to the side that was running.
- `start` held high through a game has no further effect.

## Structure
- Shared chess package holds:
  - State encoding.
  - `moveData` field positions (TURN_BIT = 13, FROM_MSB/LSB, TO_MSB/LSB, CAP_BIT = 0).
  - Countdown field positions (MIN [8:6], SEC [5:0]).
  - Side constants WHITE = 0, BLACK = 1.
- One sub-module, `tick_divider` (parameter TICKS_PER_SEC; inputs `clk`, `rst`, `en`; output `tick`), instantiated once. The rest lives in `move_sequencer`.

## Test plan
All scenarios use TICKS_PER_SEC = 4.
- **Reset then start:** reset → `moveData` = 0, `move_ready` = 0. `start` = 1 for 1 cycle → next cycle `move_ready` = 1, `sec_tick` pulses every 4th cycle thereafter.
- **Two moves:** from = 12, to = 28, capture = 0 → `moveData` = {1, 6'd12, 6'd28, 0}, `move_count` = 1. Next cycle from = 52, to = 36, capture = 1 → `moveData[13]` = 0, `move_count` = 2.
- **Null move:** from = to = 5 while ready → `illegal_move` pulses for exactly one cycle; `moveData` and `move_count` unchanged.
- **White flag fall:** in RUN_WHITE, `countdownWhite` = 10'd0 and `countdownBlack` = 10'd0 → next cycle `timeout` = 1, `winner` = 1, `move_ready` = 0, `sec_tick` stays 0. Then `start` = 1 → no change.
- **Flag fall vs. move:** in RUN_BLACK, `countdownBlack` = 0 together with a valid move 1→2 → GAME_OVER, `winner` = 0, `move_count` unchanged.
- **Saturation and mid-game reset:** 256 legal moves → `move_count` = 255. Then `rst` during RUN_BLACK → all outputs at reset values the next cycle.
